// File: rtl/i2c_byte_sequencer.sv
// Byte-level I2C master sequencer: optional START, one byte write/read with ACK, optional STOP.
// Drives open-drain enables (1 = released, 0 = pull low) and times SCL from the system clock.
module i2c_byte_sequencer #(
  parameter int unsigned QTR_CNT = 390,
  parameter int unsigned CNT_W   = 10
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_start,
  input  logic       cmd_stop,
  input  logic       cmd_read,
  input  logic       cmd_nack,
  input  logic [7:0] tx_data,
  output logic       rsp_valid,
  output logic [7:0] rx_data,
  output logic       ack_err,
  output logic       busy,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       scl_t,
  output logic       sda_t
);

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned IDX_W  = 3;
  localparam int unsigned QTR_W  = 2;
  localparam logic [CNT_W-1:0] QTR_LAST   = CNT_W'(QTR_CNT - 1);
  // A released SCL reaches scl_s through the output flop and the 2-flop
  // synchronizer; a low level seen once the counter gets here is a stretch.
  localparam logic [CNT_W-1:0] SETTLE_CNT = CNT_W'(4);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_BIT,
    S_ACK,
    S_STOP,
    S_DONE
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [CNT_W-1:0]  cnt;
  logic [QTR_W-1:0]  qtr;
  logic [IDX_W-1:0]  bit_idx;
  logic              stop_q;
  logic              read_q;
  logic              nack_q;
  logic [BYTE_W-1:0] tx_q;
  logic [BYTE_W-1:0] rx_shift;
  logic              ack_smp;
  logic              scl_s1;
  logic              scl_s;
  logic              sda_s1;
  logic              sda_s;

  logic scl_nxt;
  logic sda_nxt;
  logic ready_nxt;
  logic busy_nxt;
  logic rsp_nxt;

  logic accept;
  logic active;
  logic restart;
  logic qtr_end;
  logic phase_end;
  logic sample;

  assign accept    = cmd_valid & cmd_ready;
  assign active    = (state == S_START) || (state == S_BIT) ||
                     (state == S_ACK)   || (state == S_STOP);
  // While a slave holds SCL low in q2 the quarter restarts, so the full
  // high time is measured from the moment SCL is actually released.
  assign restart   = active && (qtr == QTR_W'(2)) && (cnt == SETTLE_CNT) && !scl_s;
  assign qtr_end   = active && (cnt == QTR_LAST) && !restart;
  assign phase_end = qtr_end && (qtr == QTR_W'(3));
  assign sample    = qtr_end && (qtr == QTR_W'(2));

  // Pad input synchronizers, idle-high
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      scl_s1 <= 1'b1;
      scl_s  <= 1'b1;
      sda_s1 <= 1'b1;
      sda_s  <= 1'b1;
    end else begin
      scl_s1 <= scl_i;
      scl_s  <= scl_s1;
      sda_s1 <= sda_i;
      sda_s  <= sda_s1;
    end
  end

  // FSM state register
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM next-state
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (accept) begin
          state_nxt = cmd_start ? S_START : S_BIT;
        end
      end
      S_START: begin
        if (phase_end) begin
          state_nxt = S_BIT;
        end
      end
      S_BIT: begin
        if (phase_end && (bit_idx == IDX_W'(0))) begin
          state_nxt = S_ACK;
        end
      end
      S_ACK: begin
        if (phase_end) begin
          state_nxt = stop_q ? S_STOP : S_DONE;
        end
      end
      S_STOP: begin
        if (phase_end) begin
          state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Output decode: next values of the registered bus and handshake outputs
  always_comb begin
    scl_nxt   = scl_t;
    sda_nxt   = sda_t;
    ready_nxt = 1'b0;
    busy_nxt  = 1'b1;
    rsp_nxt   = 1'b0;
    case (state)
      S_IDLE: begin
        ready_nxt = !accept;
        busy_nxt  = accept;
      end
      S_START: begin
        case (qtr)
          2'd0:    begin scl_nxt = 1'b0; sda_nxt = 1'b1; end
          2'd1:    begin scl_nxt = 1'b1; sda_nxt = 1'b1; end
          2'd2:    begin scl_nxt = 1'b1; sda_nxt = 1'b0; end
          default: begin scl_nxt = 1'b0; sda_nxt = 1'b0; end
        endcase
      end
      S_BIT: begin
        scl_nxt = qtr[1];
        sda_nxt = read_q ? 1'b1 : tx_q[bit_idx];
      end
      S_ACK: begin
        scl_nxt = qtr[1];
        sda_nxt = read_q ? nack_q : 1'b1;
      end
      S_STOP: begin
        case (qtr)
          2'd0:    begin scl_nxt = 1'b0; sda_nxt = 1'b0; end
          2'd1:    begin scl_nxt = 1'b1; sda_nxt = 1'b0; end
          default: begin scl_nxt = 1'b1; sda_nxt = 1'b1; end
        endcase
      end
      S_DONE: begin
        rsp_nxt = 1'b1;
        // Without STOP the bus stays owned: both lines held low.
        if (!stop_q) begin
          scl_nxt = 1'b0;
          sda_nxt = 1'b0;
        end
      end
      default: begin
        scl_nxt = 1'b1;
        sda_nxt = 1'b1;
      end
    endcase
  end

  // Registered outputs; reset releases both lines immediately
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      scl_t     <= 1'b1;
      sda_t     <= 1'b1;
      cmd_ready <= 1'b1;
      busy      <= 1'b0;
      rsp_valid <= 1'b0;
    end else begin
      scl_t     <= scl_nxt;
      sda_t     <= sda_nxt;
      cmd_ready <= ready_nxt;
      busy      <= busy_nxt;
      rsp_valid <= rsp_nxt;
    end
  end

  // Command latch, quarter/bit timing, SDA sampling and result registers
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cnt      <= '0;
      qtr      <= '0;
      bit_idx  <= IDX_W'(BYTE_W - 1);
      stop_q   <= 1'b0;
      read_q   <= 1'b0;
      nack_q   <= 1'b0;
      tx_q     <= '0;
      rx_shift <= '0;
      ack_smp  <= 1'b0;
      rx_data  <= '0;
      ack_err  <= 1'b0;
    end else begin
      if (accept) begin
        stop_q <= cmd_stop;
        read_q <= cmd_read;
        nack_q <= cmd_nack;
        tx_q   <= tx_data;
      end

      if (!active) begin
        cnt     <= '0;
        qtr     <= '0;
        bit_idx <= IDX_W'(BYTE_W - 1);
      end else if (restart) begin
        cnt <= '0;
      end else if (cnt == QTR_LAST) begin
        cnt <= '0;
        qtr <= qtr + QTR_W'(1);
        if ((qtr == QTR_W'(3)) && (state == S_BIT)) begin
          bit_idx <= bit_idx - IDX_W'(1);
        end
      end else begin
        cnt <= cnt + CNT_W'(1);
      end

      if (sample && (state == S_BIT) && read_q) begin
        rx_shift <= {rx_shift[BYTE_W-2:0], sda_s};
      end
      if (sample && (state == S_ACK)) begin
        ack_smp <= sda_s;
      end

      if (state == S_DONE) begin
        if (read_q) begin
          rx_data <= rx_shift;
        end
        ack_err <= !read_q && ack_smp;
      end
    end
  end

endmodule

// File: tb/tb_i2c_byte_sequencer.sv
// Bench for i2c_byte_sequencer: directed command table against an I2C slave/bus model.
module tb_i2c_byte_sequencer;

  localparam int unsigned Q     = 16;
  localparam int unsigned HOLD  = 1000;
  localparam int unsigned LIMIT = 4 * Q * 11 + 4000;
  localparam int unsigned NVEC  = 7;

  logic       CLK;
  logic       RST_N;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_start;
  logic       cmd_stop;
  logic       cmd_read;
  logic       cmd_nack;
  logic [7:0] tx_data;
  logic       rsp_valid;
  logic [7:0] rx_data;
  logic       ack_err;
  logic       busy;
  logic       scl_t;
  logic       sda_t;
  wire        scl_pad;
  wire        sda_pad;

  // Slave / bus model state
  logic       hold       = 1'b0;
  logic       slave_sda  = 1'b1;
  logic [8:0] slave_bits = 9'h1FF;
  logic       stretch_arm = 1'b0;
  int         hold_cnt   = 0;
  int         rise_cnt   = 9;
  int         start_cnt  = 0;
  int         stop_cnt   = 0;
  logic [7:0] cap_byte   = 8'h00;
  logic       cap_ack    = 1'b1;
  logic       prev_scl   = 1'b1;
  logic       prev_sda   = 1'b1;

  int total = 0;
  int bad   = 0;

  assign scl_pad = scl_t & ~hold;
  assign sda_pad = sda_t & slave_sda;

  i2c_byte_sequencer #(.QTR_CNT(Q), .CNT_W(10)) dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_start (cmd_start),
    .cmd_stop  (cmd_stop),
    .cmd_read  (cmd_read),
    .cmd_nack  (cmd_nack),
    .tx_data   (tx_data),
    .rsp_valid (rsp_valid),
    .rx_data   (rx_data),
    .ack_err   (ack_err),
    .busy      (busy),
    .scl_i     (scl_pad),
    .sda_i     (sda_pad),
    .scl_t     (scl_t),
    .sda_t     (sda_t)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Bus monitor + slave: START/STOP detection, bit capture, slave SDA and SCL stretching
  always @(negedge CLK) begin
    logic cur_scl;
    logic cur_sda;
    cur_scl = scl_pad;
    cur_sda = sda_pad;
    if (prev_scl && cur_scl && (prev_sda != cur_sda)) begin
      if (!cur_sda) begin
        start_cnt++;
        rise_cnt = 0;
      end else begin
        stop_cnt++;
      end
    end
    if (!prev_scl && cur_scl && (rise_cnt < 9)) begin
      if (rise_cnt < 8) cap_byte = {cap_byte[6:0], cur_sda};
      else cap_ack = cur_sda;
      rise_cnt++;
    end
    if (prev_scl && !cur_scl) begin
      if (rise_cnt < 9) begin
        slave_sda = slave_bits[8 - rise_cnt];
        if (stretch_arm && (rise_cnt == 3)) begin
          hold        = 1'b1;
          stretch_arm = 1'b0;
          hold_cnt    = 0;
        end
      end else begin
        slave_sda = 1'b1;
      end
    end
    if (hold && scl_t) begin
      hold_cnt++;
      if (hold_cnt >= HOLD) hold = 1'b0;
    end
    prev_scl = cur_scl;
    prev_sda = cur_sda;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic       start;
    logic       stop;
    logic       read;
    logic       nack;
    logic [7:0] tx;
    logic [7:0] sbyte;       // slave drive during the 8 bit slots (1 = release)
    logic       sack;        // slave drive during the ACK slot
    logic       stretch;
    logic [7:0] exp_rx;
    logic       exp_ack_err;
    logic [7:0] exp_bus;     // byte seen on SDA at SCL rising edges
    logic       exp_bus_ack;
    logic [1:0] exp_lines;   // {scl_t, sda_t} after completion
  } vec_t;

  vec_t vecs [NVEC];

  task automatic run_vec(input int idx, input vec_t v);
    int n;
    int lat;
    int nominal;
    int s0;
    int p0;
    nominal = 4 * Q * (9 + int'(v.start) + int'(v.stop)) + 1;
    @(negedge CLK);
    slave_bits  = {v.sbyte, v.sack};
    stretch_arm = v.stretch;
    if (v.start) begin
      rise_cnt  = 9;
      slave_sda = 1'b1;
    end else begin
      rise_cnt  = 0;
      slave_sda = v.sbyte[7];
    end
    s0 = start_cnt;
    p0 = stop_cnt;
    cmd_start = v.start;
    cmd_stop  = v.stop;
    cmd_read  = v.read;
    cmd_nack  = v.nack;
    tx_data   = v.tx;
    cmd_valid = 1'b1;
    check($sformatf("v%0d_ready_idle", idx), 32'(cmd_ready), 32'd1);
    @(posedge CLK);
    @(negedge CLK);
    cmd_valid = 1'b0;
    check($sformatf("v%0d_accept", idx), 32'({busy, cmd_ready}), 32'b10);
    n = 1;
    while ((rsp_valid !== 1'b1) && (n < LIMIT)) begin
      @(negedge CLK);
      n++;
    end
    lat = n - 1;
    if (v.stretch) begin
      total++;
      if ((lat < nominal + int'(HOLD)) || (lat > nominal + int'(HOLD) + 4 * Q)) begin
        bad++;
        $display("FAIL v%0d_latency: got %0d expected %0d..%0d", idx, lat,
                 nominal + int'(HOLD), nominal + int'(HOLD) + 4 * Q);
      end
    end else begin
      check($sformatf("v%0d_latency", idx), 32'(lat), 32'(nominal));
    end
    check($sformatf("v%0d_ack_err", idx), 32'(ack_err), 32'(v.exp_ack_err));
    if (v.read) check($sformatf("v%0d_rx_data", idx), 32'(rx_data), 32'(v.exp_rx));
    @(negedge CLK);
    check($sformatf("v%0d_after", idx), 32'({rsp_valid, busy, cmd_ready}), 32'b001);
    check($sformatf("v%0d_lines", idx), 32'({scl_t, sda_t}), 32'(v.exp_lines));
    check($sformatf("v%0d_bus_byte", idx), 32'(cap_byte), 32'(v.exp_bus));
    check($sformatf("v%0d_bus_ack", idx), 32'(cap_ack), 32'(v.exp_bus_ack));
    check($sformatf("v%0d_starts", idx), 32'(start_cnt - s0), 32'(v.start));
    check($sformatf("v%0d_stops", idx), 32'(stop_cnt - p0), 32'(v.stop));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int stuck;
    int w;
    RST_N     = 1'b0;
    cmd_valid = 1'b0;
    cmd_start = 1'b0;
    cmd_stop  = 1'b0;
    cmd_read  = 1'b0;
    cmd_nack  = 1'b0;
    tx_data   = 8'h00;

    //          st    sp    rd    nk    tx     sbyte  sack  str   rx     aerr  bus    bak   lines
    vecs[0] = '{1'b1, 1'b1, 1'b0, 1'b0, 8'hA4, 8'hFF, 1'b0, 1'b0, 8'h00, 1'b0, 8'hA4, 1'b0, 2'b11};
    vecs[1] = '{1'b1, 1'b1, 1'b1, 1'b1, 8'h00, 8'h5C, 1'b1, 1'b0, 8'h5C, 1'b0, 8'h5C, 1'b1, 2'b11};
    vecs[2] = '{1'b1, 1'b0, 1'b0, 1'b0, 8'h3C, 8'hFF, 1'b1, 1'b0, 8'h00, 1'b1, 8'h3C, 1'b1, 2'b00};
    vecs[3] = '{1'b1, 1'b1, 1'b0, 1'b0, 8'h96, 8'hFF, 1'b0, 1'b0, 8'h00, 1'b0, 8'h96, 1'b0, 2'b11};
    vecs[4] = '{1'b1, 1'b1, 1'b0, 1'b0, 8'h5A, 8'hFF, 1'b0, 1'b1, 8'h00, 1'b0, 8'h5A, 1'b0, 2'b11};
    vecs[5] = '{1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 8'h3B, 1'b1, 1'b0, 8'h3B, 1'b0, 8'h3B, 1'b0, 2'b00};
    vecs[6] = '{1'b0, 1'b1, 1'b1, 1'b1, 8'h00, 8'hC6, 1'b1, 1'b0, 8'hC6, 1'b0, 8'hC6, 1'b1, 2'b11};

    // Reset state
    repeat (3) @(negedge CLK);
    check("reset_outputs", 32'({scl_t, sda_t, cmd_ready, busy, rsp_valid, ack_err, rx_data}),
          32'b11_1_0_0_0_00000000);
    RST_N = 1'b1;
    repeat (2) @(negedge CLK);
    check("reset_release", 32'({scl_t, sda_t, cmd_ready, busy}), 32'b1110);

    for (int i = 0; i < int'(NVEC); i++) begin
      run_vec(i, vecs[i]);
    end

    // cmd_valid held high while busy must not be accepted
    @(negedge CLK);
    rise_cnt    = 9;
    slave_sda   = 1'b1;
    slave_bits  = 9'h1FF;
    stretch_arm = 1'b0;
    cmd_start   = 1'b1;
    cmd_stop    = 1'b1;
    cmd_read    = 1'b0;
    cmd_nack    = 1'b0;
    tx_data     = 8'h81;
    cmd_valid   = 1'b1;
    @(posedge CLK);
    stuck = 0;
    for (int k = 0; k < 300; k++) begin
      @(negedge CLK);
      if ((cmd_ready !== 1'b0) || (busy !== 1'b1) || (rsp_valid !== 1'b0)) stuck++;
    end
    check("busy_ignore", 32'(stuck), 32'd0);

    // Reset pulsed mid-byte while SCL is driven low
    w = 0;
    while ((scl_t !== 1'b0) && (w < 4 * Q)) begin
      @(negedge CLK);
      w++;
    end
    check("mid_scl_low", 32'(scl_t), 32'd0);
    RST_N = 1'b0;
    #1;
    check("rst_lines", 32'({scl_t, sda_t}), 32'b11);
    check("rst_flags", 32'({cmd_ready, busy, rsp_valid, ack_err, rx_data}), 32'b1_0_0_0_00000000);
    cmd_valid = 1'b0;
    @(negedge CLK);
    RST_N = 1'b1;
    repeat (2) @(negedge CLK);
    check("post_rst", 32'({cmd_ready, busy, scl_t, sda_t}), 32'b1011);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
